// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seven-segment display arbiter
// Purpose: widths, digit codes and the arbiter state type used by seg7_display_arbiter and bin2bcd_seq.
// Ports: none (package).
package seg7_pkg;
  localparam int VAL_W = 14;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'd15;
  localparam logic [BCD_W-1:0] BCD_ERR   = 4'd10;
  localparam logic [VAL_W-1:0] MAX_VAL   = 14'd9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } arb_state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter (double-dabble)
// Purpose: loads bin on start, performs 14 add-3/shift steps, then raises done for one cycle.
// Ports: clk, rst (async, active-high), start (load pulse), bin[13:0], done (result-ready pulse),
//        d_thou/d_hund/d_tens/d_unit (BCD digits, valid while done is high).
module bin2bcd_seq import seg7_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] d_thou,
  output logic [BCD_W-1:0] d_hund,
  output logic [BCD_W-1:0] d_tens,
  output logic [BCD_W-1:0] d_unit
);
  logic [VAL_W-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [3:0]       r_cnt;
  logic             r_run;
  logic [15:0]      w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // start always restarts the engine, so an aborted conversion never leaks into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= 4'd14;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt != 4'd0) begin
        r_bcd <= {w_adj[14:0], r_bin[VAL_W-1]};
        r_bin <= {r_bin[VAL_W-2:0], 1'b0};
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign done   = r_run && (r_cnt == 4'd0);
  assign d_thou = r_bcd[15:12];
  assign d_hund = r_bcd[11:8];
  assign d_tens = r_bcd[7:4];
  assign d_unit = r_bcd[3:0];
endmodule

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - fixed-priority arbiter sharing one 4-digit BCD display
// Purpose: grants the lowest-index requester, converts its value to BCD in 15 cycles and holds
//          the result on the display for at least HOLD_CYCLES before re-arbitrating.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (units never blanked).
// Ports: clk, rst (async, active-high), req[N_REQ], value[N_REQ*14], ack[N_REQ] (grant pulse),
//        clear (sync blank/abort), bcd_data_0..3 (thousands..units), valid, busy, owner.
module seg7_display_arbiter import seg7_pkg::*; #(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [N_REQ-1:0]                           req,
  input  logic [N_REQ*VAL_W-1:0]                     value,
  output logic [N_REQ-1:0]                           ack,
  input  logic                                       clear,
  output logic [BCD_W-1:0]                           bcd_data_0,
  output logic [BCD_W-1:0]                           bcd_data_1,
  output logic [BCD_W-1:0]                           bcd_data_2,
  output logic [BCD_W-1:0]                           bcd_data_3,
  output logic                                       valid,
  output logic                                       busy,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  arb_state_t       r_state, w_next;
  logic [N_REQ-1:0] r_ack;
  logic [OWN_W-1:0] r_owner, w_idx;
  logic [VAL_W-1:0] r_value, w_slice;
  logic [CNT_W-1:0] r_hold;
  logic [BCD_W-1:0] r_d0, r_d1, r_d2, r_d3;
  logic             r_valid;
  logic             w_any, w_grant, w_hold_done, w_done;
  logic [BCD_W-1:0] w_n0, w_n1, w_n2, w_n3;
  logic [BCD_W-1:0] w_f0, w_f1, w_f2, w_f3;

  // Scan from the top down so the lowest asserted index is the last one written.
  always_comb begin
    w_any   = 1'b0;
    w_idx   = '0;
    w_slice = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any   = 1'b1;
        w_idx   = OWN_W'(i);
        w_slice = value[VAL_W*i +: VAL_W];
      end
    end
  end

  assign w_hold_done = (r_hold >= HOLD_MAX);
  assign w_grant = !clear && w_any &&
                   ((r_state == IDLE) || ((r_state == SHOW) && w_hold_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = CONVERT;
      CONVERT: if (clear) w_next = IDLE; else if (w_done) w_next = SHOW;
      SHOW:    if (clear) w_next = IDLE; else if (w_grant) w_next = CONVERT;
      default: w_next = IDLE;
    endcase
  end

  bin2bcd_seq u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (w_grant),
    .bin    (w_slice),
    .done   (w_done),
    .d_thou (w_n0),
    .d_hund (w_n1),
    .d_tens (w_n2),
    .d_unit (w_n3)
  );

  // Final digit formatting; the engine drops the ten-thousands digit, so overflow is judged on r_value.
  always_comb begin
    w_f0 = w_n0;
    w_f1 = w_n1;
    w_f2 = w_n2;
    w_f3 = w_n3;
    if (r_value > MAX_VAL) begin
      w_f0 = BCD_ERR;
      w_f1 = BCD_ERR;
      w_f2 = BCD_ERR;
      w_f3 = BCD_ERR;
    end else begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (w_n0 == 4'd0) begin
        w_f0 = BCD_BLANK;
        if (w_n1 == 4'd0) begin
          w_f1 = BCD_BLANK;
          if (w_n2 == 4'd0) w_f2 = BCD_BLANK;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= '0;
      r_owner <= '0;
      r_value <= '0;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_d0    <= BCD_BLANK;
      r_d1    <= BCD_BLANK;
      r_d2    <= BCD_BLANK;
      r_d3    <= BCD_BLANK;
    end else begin
      r_ack <= '0;
      if (clear) begin
        r_valid <= 1'b0;
        r_hold  <= '0;
        r_d0    <= BCD_BLANK;
        r_d1    <= BCD_BLANK;
        r_d2    <= BCD_BLANK;
        r_d3    <= BCD_BLANK;
      end else if (w_grant) begin
        r_ack   <= N_REQ'(1) << w_idx;
        r_owner <= w_idx;
        r_value <= w_slice;
      end else if ((r_state == CONVERT) && w_done) begin
        r_d0    <= w_f0;
        r_d1    <= w_f1;
        r_d2    <= w_f2;
        r_d3    <= w_f3;
        r_valid <= 1'b1;
        r_hold  <= '0;
      end else if ((r_state == SHOW) && !w_hold_done) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign ack        = r_ack;
  assign owner      = r_owner;
  assign valid      = r_valid;
  assign busy       = (r_state == CONVERT);
  assign bcd_data_0 = r_d0;
  assign bcd_data_1 = r_d1;
  assign bcd_data_2 = r_d2;
  assign bcd_data_3 = r_d3;
endmodule

// File: doc/seg7_display_arbiter.md
Name: seg7_display_arbiter

Overview:
Shares the single 4-digit seven-segment display between N_REQ requesters (e.g. calculator result, error code, countdown).
- Arbitrates by fixed priority.
- Latches the winner's 14-bit binary value and converts it to BCD with a sequential double-dabble.
- Drives the display driver's bcd_data_0..3/valid inputs.
- Holds each shown value for at least HOLD_CYCLES before another requester may take over.

Parameters:
N_REQ, 3, number of requesters; index 0 is highest priority.
HOLD_CYCLES, 100_000_000, minimum clocks a granted value stays displayed before re-arbitration (1 s at 100 MHz).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request level; held with value until ack
value  input  N_REQ*14  packed binary values; requester i occupies bits [14*i+13:14*i]
ack  output  N_REQ  one-cycle registered grant pulse; value is latched on the same edge
clear  input  1  synchronous blank/abort command
bcd_data_0  output  4  thousands digit (leftmost)
bcd_data_1  output  4  hundreds digit
bcd_data_2  output  4  tens digit
bcd_data_3  output  4  units digit
valid  output  1  display enable to driver
busy  output  1  high in CONVERT
owner  output  $clog2(N_REQ) (min 1)  index of requester currently shown

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0; busy=0; valid=0; owner=0; all bcd_data=4'd15 (blank); hold counter=0.
- States:
  - IDLE: nothing shown.
  - CONVERT: 14 shift cycles.
  - SHOW: value displayed; hold counter runs.
- Arbitration:
  - Evaluated in IDLE, and in SHOW once hold counter >= HOLD_CYCLES-1.
  - Lowest asserted req index wins.
  - Grant edge: ack[i] pulses high for exactly one cycle, value slice is latched, owner<=i, state->CONVERT.
  - No grant in CONVERT; req is ignored there.
- Preemption: none during the hold window. After the hold expires, any req, including the current owner's, re-arbitrates. If no req arrives, SHOW persists indefinitely with the counter saturated.
- Conversion:
  - Double-dabble over 14 edges. Per edge, each BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - On the 15th edge after the grant edge: bcd_data load, valid<=1, busy<=0, hold counter<=0, state->SHOW.
  - Latency is fixed at 15 cycles, including overflow.
  - During CONVERT, outputs keep their previous values (old value or blank) and busy=1.
- Overflow: latched value >9999 -> all four digits = 4'd10 ('E'), after the same 15-cycle latency.
- clear:
  - Priority over everything except reset.
  - Next edge: state IDLE, valid=0, digits=4'd15, busy=0, in-flight conversion discarded.
  - clear together with req: no grant, no ack.
- Boundaries:
  - value 0 -> 0,0,0,0.
  - value 9999 -> 9,9,9,9.
  - A req dropped before ack is never granted.
  - Hold counter width is $clog2(HOLD_CYCLES+1) and saturates (no wrap).
  - HOLD_CYCLES=1: re-arbitration is allowed on the first SHOW cycle.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: when loading non-overflow digits, leading zero digits become 4'd15 (blank), scanning from bcd_data_0 toward bcd_data_2. bcd_data_3 is never blanked, so 0 shows as "   0" and 42 as "  42".
- Undefined: zeros are shown as-is ("0042").
- Latency is identical either way.

Decomposition:
Package seg7_pkg:
- VAL_W=14, BCD_W=4.
- BCD_BLANK=4'd15, BCD_ERR=4'd10, MAX_VAL=14'd9999.
- State enum arb_state_t {IDLE, CONVERT, SHOW}.

Sub-module bin2bcd_seq:
- Ports: clk, rst, start, bin[13:0], done pulse, four BCD nibbles.
- Contains the 14-step shift engine and its step counter.
- Arbiter owns priority logic, hold counter, overflow/blanking and output registers.

Test Plan:
1. Reset then req=3'b001, value0=1234 -> ack=3'b001 one cycle; 15 cycles later digits 1,2,3,4 and valid=1; owner=0.
2. req0 and req2 asserted together (value0=7, value2=5678) -> ack[0] only; display 0,0,0,7 (macro on: 15,15,15,7); req2 granted only after HOLD_CYCLES (set to 8) elapse.
3. value1=10000, req1 -> digits 10,10,10,10 after 15 cycles; value1=9999 -> 9,9,9,9; value1=0 -> 0,0,0,0 (macro on: 15,15,15,0).
4. clear asserted mid-CONVERT (cycle 6) -> next cycle valid=0, digits 15, busy=0; old SHOW value never reappears; clear with req in the same cycle -> no ack.
5. req1 held through CONVERT and SHOW with HOLD_CYCLES=4 -> exactly one ack per hold window; a req2 pulse dropped before grant -> never acked.
6. rst asserted mid-CONVERT and mid-SHOW -> same cycle (async): valid=0, ack=0, busy=0, digits 15, owner=0.
